// File: rtl/alu_md_control_if.sv
// Decode-side bundle between the instruction pipeline and alu_md_control.
interface alu_md_control_if #(
  parameter int CTRL_W = 4
);
  logic              valid_in;
  logic [1:0]        ALUOpcode;
  logic [5:0]        op_5_0;
  logic [CTRL_W-1:0] ALUControl;
  logic              ctrl_valid;
  logic              md_start;
  logic [1:0]        md_op;
  logic              stall;
  logic              hilo_we;
  logic              illegal_op;

  modport master (
    output valid_in, ALUOpcode, op_5_0,
    input  ALUControl, ctrl_valid, md_start, md_op, stall, hilo_we, illegal_op
  );

  modport slave (
    input  valid_in, ALUOpcode, op_5_0,
    output ALUControl, ctrl_valid, md_start, md_op, stall, hilo_we, illegal_op
  );
endinterface

// File: rtl/alu_md_control.sv
// ALU control decoder with multiply/divide sequencing (IDLE/BUSY/DONE).
// Optional feature: define ALU_CTRL_ILLEGAL_TRAP_EN to flag undefined encodings on illegal_op.
module alu_md_control #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_md_control_if.slave bus
);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              cv_q, cv_d;
  logic              start_q, start_d;
  logic [1:0]        op_q, op_d;
  logic              hilo_q, hilo_d;
  logic              ill_q, ill_d;

  logic [3:0]        dec_code;
  logic              dec_md;
  logic              dec_illegal;
  logic              accept;

  always_comb begin
    dec_code    = 4'b0010;
    dec_md      = 1'b0;
    dec_illegal = 1'b0;
    case (bus.ALUOpcode)
      2'b00: dec_code = 4'b0010;
      2'b01: dec_code = 4'b0110;
      2'b10: begin
        case (bus.op_5_0)
          6'b100000, 6'b100001: dec_code = 4'b0010;
          6'b100010, 6'b100011: dec_code = 4'b0110;
          6'b100100: dec_code = 4'b0000;
          6'b100101: dec_code = 4'b0001;
          6'b100110: dec_code = 4'b0011;
          6'b100111: dec_code = 4'b1100;
          6'b101010: dec_code = 4'b0111;
          6'b101011: dec_code = 4'b1000;
          6'b000000: dec_code = 4'b1001;
          6'b000010: dec_code = 4'b1010;
          6'b000011: dec_code = 4'b1011;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_md = 1'b1;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign accept = bus.valid_in && (state_q != BUSY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    cv_d    = 1'b0;
    start_d = 1'b0;
    op_d    = op_q;
    // hilo_we trails DONE by one cycle so a back-to-back op's md_start lines up with it
    hilo_d  = (state_q == DONE);
    ill_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (dec_md) begin
            state_d = BUSY;
            start_d = 1'b1;
            op_d    = bus.op_5_0[1:0];
            cnt_d   = bus.op_5_0[1] ? DIV_LOAD : MUL_LOAD;
          end else begin
            ctrl_d = CTRL_W'(dec_code);
            cv_d   = 1'b1;
            ill_d  = TRAP_EN && dec_illegal;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      cv_q    <= 1'b0;
      start_q <= 1'b0;
      op_q    <= '0;
      hilo_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      cv_q    <= cv_d;
      start_q <= start_d;
      op_q    <= op_d;
      hilo_q  <= hilo_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.ALUControl = ctrl_q;
  assign bus.ctrl_valid = cv_q;
  assign bus.md_start   = start_q;
  assign bus.md_op      = op_q;
  assign bus.stall      = (state_q == BUSY);
  assign bus.hilo_we    = hilo_q;
  assign bus.illegal_op = ill_q;

endmodule

// File: doc/alu_md_control.md
ALU_MD_CONTROL -- requirements
Module: alu_md_control

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 4, width of the ALU control code (minimum 4; codes zero-extended above bit 3).
REQ-002 The block SHALL have parameter MUL_LAT, default 4, cycles a MULT/MULTU occupies the multiply/divide unit (minimum 2).
REQ-003 The block SHALL have parameter DIV_LAT, default 32, cycles a DIV/DIVU occupies the multiply/divide unit (minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port valid_in, input, 1 bit, instruction presented this cycle.
REQ-007 The block SHALL have port ALUOpcode, input, 2 bits, main-decoder ALU op class.
REQ-008 The block SHALL have port op_5_0, input, 6 bits, R-type funct field.
REQ-009 The block SHALL have port ALUControl, output, CTRL_W bits, registered ALU operation code.
REQ-010 The block SHALL have port ctrl_valid, output, 1 bit, ALUControl holds a newly decoded code this cycle.
REQ-011 The block SHALL have port md_start, output, 1 bit, one-cycle start pulse to the multiply/divide unit.
REQ-012 The block SHALL have port md_op, output, 2 bits, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU, valid with md_start.
REQ-013 The block SHALL have port stall, output, 1 bit, upstream holds its instruction while high.
REQ-014 The block SHALL have port hilo_we, output, 1 bit, one-cycle HI/LO write enable at operation completion.
REQ-015 The block SHALL have port illegal_op, output, 1 bit, registered undefined-encoding flag (see Configuration).

Function
REQ-016 Decode SHALL be accepted when valid_in=1 and stall=0; results register on that edge (latency 1 cycle); ctrl_valid=1 for exactly the following cycle, else 0.
REQ-017 ALUOpcode 00 SHALL yield 0010 (add); 01 SHALL yield 0110 (sub); 11 is undefined.
REQ-018 ALUOpcode 10 SHALL decode full funct: 100000/100001→0010, 100010/100011→0110, 100100→0000, 100101→0001, 100110→0011, 100111→1100, 101010→0111, 101011→1000, 000000→1001, 000010→1010, 000011→1011.
REQ-019 Funct 011000/011001/011010/011011 SHALL set md_op 00/01/10/11, pulse md_start next cycle, leave ALUControl unchanged, ctrl_valid=0.
REQ-020 Undefined encodings SHALL yield ALUControl 0010; ALUControl SHALL hold its value when nothing is accepted.
REQ-021 FSM states IDLE, BUSY, DONE; IDLE/DONE + accepted md funct → BUSY with counter loaded LAT-1 (MUL_LAT or DIV_LAT per md_op).
REQ-022 BUSY SHALL decrement the counter each cycle; counter=0 → DONE; counter width $clog2(max(MUL_LAT,DIV_LAT)), no wrap.
REQ-023 stall SHALL equal (state==BUSY); total stall cycles per md op SHALL equal its LAT.
REQ-024 DONE SHALL assert hilo_we for one cycle then return to IDLE unless a new md op is accepted that same cycle (back-to-back → BUSY, hilo_we still 1).
REQ-025 Non-md instructions accepted in DONE SHALL decode normally; valid_in in BUSY SHALL be ignored.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, counter 0, ALUControl 0, ctrl_valid 0, md_start 0, md_op 00, stall 0, hilo_we 0, illegal_op 0, including mid-BUSY (operation discarded, no hilo_we).
REQ-027 Release SHALL take effect at the first rising clk after rst returns to 1.

Configuration
REQ-028 With ALU_CTRL_ILLEGAL_TRAP_EN defined, illegal_op SHALL be 1 for the cycle after accepting ALUOpcode 11 or an undefined funct, and no md_start SHALL be issued.
REQ-029 Without ALU_CTRL_ILLEGAL_TRAP_EN, illegal_op SHALL be tied 0 and undefined encodings decode silently as add.

Verification
REQ-030 Reset then ALUOpcode 10, funct 100111, valid → next cycle ALUControl 1100, ctrl_valid 1, stall 0.
REQ-031 funct 011000 accepted with MUL_LAT=4 → md_start/md_op 00 next cycle, stall high exactly 4 cycles, hilo_we 1 the cycle after stall falls.
REQ-032 DIVU then, in DONE, MULT accepted → hilo_we 1 and md_start 1 same cycle, stall resumes for MUL_LAT.
REQ-033 rst=0 during BUSY of DIV (cycle 10 of 32) → all outputs 0 asynchronously, no hilo_we after release.
REQ-034 ALUOpcode 11 with macro defined → illegal_op 1, ALUControl 0010; without macro → illegal_op 0.
REQ-035 valid_in toggled with ALUOpcode 01 while stall=1 → ALUControl unchanged, ctrl_valid 0 until DONE.
